// File: rtl/pwmcap_pkg.sv
// Shared types and helpers for the PWM capture path.
// Period derivation and duty saturation live here so the top stays parameter-clean.
package pwmcap_pkg;

  typedef enum logic {
    HUNT  = 1'b0,
    TRACK = 1'b1
  } state_t;

  function automatic int unsigned period_of(input int unsigned cnt_w);
    return 32'd1 << cnt_w;
  endfunction

  // A full-high period measures 2^cnt_w, one beyond the sample range.
  function automatic logic [31:0] sat_duty(input logic [31:0] cnt, input int unsigned cnt_w);
    logic [31:0] max_v;
    max_v = (32'd1 << cnt_w) - 32'd1;
    return (cnt > max_v) ? max_v : cnt;
  endfunction

endpackage

// File: rtl/pwmcap_sync.sv
// Two-flop synchroniser for the asynchronous PWM pin plus rising-edge detect.
// Latency: pwm_s_o two cycles after the pin; rise_o combinational on pwm_s_o. No backpressure.
module pwmcap_sync (
  input  logic clk,
  input  logic rstn,
  input  logic pwm_i,
  output logic pwm_s_o,
  output logic rise_o
);

  logic r_meta;
  logic r_sync;
  logic r_dly;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_dly  <= 1'b0;
    end else begin
      r_meta <= pwm_i;
      r_sync <= r_meta;
      r_dly  <= r_sync;
    end
  end

  assign pwm_s_o = r_sync;
  assign rise_o  = r_sync & ~r_dly;

endmodule

// File: rtl/pwm_capture.sv
// Recovers duty samples from a fixed-period PWM stream; PWMCAP_AVG_EN selects a 4-tap moving average.
// Latency: pin rise to sample_valid_o in 3 cycles (4 with averaging). Backpressure: none upstream;
// an unconsumed sample is overwritten and flagged on overrun_o.
module pwm_capture
  import pwmcap_pkg::*;
#(
  parameter int unsigned CNT_W    = 11,
  parameter int unsigned TOL      = 4,
  parameter int unsigned LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             pwm_i,
  output logic [CNT_W-1:0] sample_o,
  output logic             sample_valid_o,
  input  logic             sample_ready_i,
  output logic             locked_o,
  output logic             period_err_o,
  output logic             overrun_o
);

  localparam int unsigned PW     = CNT_W + 2;
  localparam int unsigned HW     = CNT_W + 1;
  localparam int unsigned GW     = $clog2(LOCK_CNT + 1);
  localparam int unsigned PERIOD = period_of(CNT_W);
  localparam logic [PW-1:0]    P_MIN = PW'(PERIOD - TOL);
  localparam logic [PW-1:0]    P_MAX = PW'(PERIOD + TOL);
  localparam logic [CNT_W-1:0] D_MAX = '1;

  logic             w_pwm_s;
  logic             w_rise;
  logic             w_timeout;
  logic             w_per_ok;
  logic [PW-1:0]    r_per;
  logic [HW-1:0]    r_high;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [GW-1:0]    r_good;
  logic [GW-1:0]    w_good_nxt;
  logic             w_emit;
  logic             w_bad;
  logic             w_lock_nxt;
  logic [CNT_W-1:0] w_duty;

  logic             w_o_emit;
  logic             w_o_bad;
  logic             w_o_lock;
  logic [CNT_W-1:0] w_o_sample;

  logic [CNT_W-1:0] r_sample;
  logic             r_valid;
  logic             r_locked;
  logic             r_err;
  logic             r_ovr;

  pwmcap_sync u_sync (
    .clk     (clk),
    .rstn    (rstn),
    .pwm_i   (pwm_i),
    .pwm_s_o (w_pwm_s),
    .rise_o  (w_rise)
  );

  // The timeout reload keeps r_per from ever passing P_MAX.
  assign w_timeout = !w_rise && (r_per >= P_MAX);
  assign w_per_ok  = (r_per >= P_MIN) && (r_per <= P_MAX);
  assign w_duty    = w_rise ? CNT_W'(sat_duty(32'(r_high), CNT_W))
                            : (w_pwm_s ? D_MAX : '0);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_per  <= '0;
      r_high <= '0;
    end else if (w_rise) begin
      r_per  <= PW'(1);
      r_high <= HW'(1);
    end else if (w_timeout) begin
      r_per  <= PW'(1);
      r_high <= HW'(w_pwm_s);
    end else begin
      r_per  <= r_per + 1'b1;
      r_high <= r_high + HW'(w_pwm_s);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= HUNT;
      r_good  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_good  <= w_good_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good;
    w_emit      = 1'b0;
    w_bad       = 1'b0;
    case (r_state)
      HUNT: begin
        if (w_rise || w_timeout) w_state_nxt = TRACK;
      end
      TRACK: begin
        if (w_rise && !w_per_ok) begin
          w_bad      = 1'b1;
          w_good_nxt = '0;
        end else if (w_rise || w_timeout) begin
          w_emit = 1'b1;
          if (r_good < GW'(LOCK_CNT)) w_good_nxt = r_good + 1'b1;
        end
      end
      default: w_state_nxt = HUNT;
    endcase
  end

  assign w_lock_nxt = (w_good_nxt >= GW'(LOCK_CNT));

`ifdef PWMCAP_AVG_EN
  logic [CNT_W-1:0] r_hist [4];
  logic             r_p_emit;
  logic             r_p_bad;
  logic             r_p_lock;
  logic [CNT_W+1:0] w_sum;

  // History updates on the event cycle; the average is registered one cycle later.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < 4; i++) r_hist[i] <= '0;
      r_p_emit <= 1'b0;
      r_p_bad  <= 1'b0;
      r_p_lock <= 1'b0;
    end else begin
      r_p_emit <= w_emit;
      r_p_bad  <= w_bad;
      r_p_lock <= w_lock_nxt;
      if (w_bad) begin
        for (int i = 0; i < 4; i++) r_hist[i] <= '0;
      end else if (w_emit) begin
        r_hist[0] <= w_duty;
        for (int i = 1; i < 4; i++) r_hist[i] <= r_hist[i-1];
      end
    end
  end

  assign w_sum      = {2'b00, r_hist[0]} + {2'b00, r_hist[1]}
                    + {2'b00, r_hist[2]} + {2'b00, r_hist[3]};
  assign w_o_emit   = r_p_emit;
  assign w_o_bad    = r_p_bad;
  assign w_o_lock   = r_p_lock;
  assign w_o_sample = w_sum[CNT_W+1:2];
`else
  assign w_o_emit   = w_emit;
  assign w_o_bad    = w_bad;
  assign w_o_lock   = w_lock_nxt;
  assign w_o_sample = w_duty;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_sample <= '0;
      r_valid  <= 1'b0;
      r_locked <= 1'b0;
      r_err    <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      r_err    <= w_o_bad;
      r_locked <= w_o_lock;
      if (w_o_emit) begin
        r_sample <= w_o_sample;
        r_valid  <= 1'b1;
        if (r_valid && !sample_ready_i) r_ovr <= 1'b1;
      end else if (r_valid && sample_ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign sample_o       = r_sample;
  assign sample_valid_o = r_valid;
  assign locked_o       = r_locked;
  assign period_err_o   = r_err;
  assign overrun_o      = r_ovr;

endmodule
